// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial values into a magnitude comparator
// and resolves the unknown target MSB-first, stopping early on an exact match.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       cmp_less,
    input  logic                       cmp_greater,
    input  logic                       cmp_equal,
    output logic [WIDTH-1:0]           guess,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       found,
    output logic                       err,
    output logic [$clog2(WIDTH+1)-1:0] steps
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             done_q, done_d;
    logic             legal;
    logic [WIDTH-1:0] acc;

    // Exactly one of the three flags may be high.
    assign legal = (cmp_less ^ cmp_greater ^ cmp_equal) & ~(cmp_less & cmp_greater & cmp_equal);

    // result_q holds the bits already resolved above idx; a "less" keeps the trial bit.
    assign acc = cmp_less ? guess_q : result_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        steps_d  = steps_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    steps_d  = '0;
                    idx_d    = IW'(WIDTH - 1);
                    guess_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    state_d  = StEval;
                end
            end
            StEval: begin
                steps_d = steps_q + SW'(1);
                if (!legal) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (cmp_equal) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = StDone;
                end else begin
                    result_d = acc;
                    if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        guess_d = acc | (WIDTH'(1) << (idx_q - IW'(1)));
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= IW'(WIDTH - 1);
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            steps_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            steps_q  <= steps_d;
            done_q   <= done_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == StEval);
    assign done   = done_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator closes the loop, a table of
// searches plus a full target sweep feed a scoreboard, and hand sequences cover reset/start.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cmp_less, cmp_greater, cmp_equal;
    logic [3:0] guess, result;
    logic       busy, done, found, err;
    logic [2:0] steps;

    logic [3:0] target = 4'd0;
    logic       flags_off = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  target;
        logic [3:0]  res;
        logic        found;
        logic        err;
        logic [2:0]  steps;
        logic [15:0] gseq;      // first guess in [3:0]
        int          bad_step;  // EVAL cycle whose flags are forced to zero, -1 for none
        bit          poke;      // hold start high while busy
    } vec_t;

    vec_t       tbl[6];
    vec_t       exp_q[$];
    logic [3:0] gexp_q[$];

    always #5 clk = ~clk;

    assign cmp_less    = !flags_off && (guess < target);
    assign cmp_greater = !flags_off && (guess > target);
    assign cmp_equal   = !flags_off && (guess == target);

    sar_search #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmp_less    (cmp_less),
        .cmp_greater (cmp_greater),
        .cmp_equal   (cmp_equal),
        .guess       (guess),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .found       (found),
        .err         (err),
        .steps       (steps)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference binary search against a stable target.
    function automatic vec_t model(input logic [3:0] t);
        vec_t       v;
        logic [3:0] acc, g;
        bit         hit;
        acc = 4'd0;
        hit = 1'b0;
        v.target = t; v.found = 1'b0; v.err = 1'b0; v.steps = 3'd0; v.gseq = 16'd0;
        v.bad_step = -1; v.poke = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!hit) begin
                g = acc | (4'd1 << i);
                v.gseq[4*(3-i) +: 4] = g;
                v.steps++;
                if (g == t) begin
                    hit = 1'b1;
                    acc = g;
                end else if (g < t) begin
                    acc = g;
                end
            end
        end
        v.res = acc;
        v.found = hit;
        return v;
    endfunction

    task automatic run(input vec_t v);
        vec_t e;
        int   cyc;
        bit   seen;
        target = v.target;
        gexp_q.delete();
        exp_q.push_back(v);
        for (int i = 0; i < int'(v.steps); i++) gexp_q.push_back(v.gseq[4*i +: 4]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 12) begin
            if (busy) begin
                flags_off = (cyc == v.bad_step);
                start = v.poke;
                if (gexp_q.size() == 0) check($sformatf("extra_eval_t%0d", v.target), 1, 0);
                else check($sformatf("guess_t%0d_c%0d", v.target, cyc), guess, gexp_q.pop_front());
            end else begin
                flags_off = 1'b0;
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                check($sformatf("result_t%0d", e.target), result, e.res);
                check($sformatf("found_t%0d", e.target), found, e.found);
                check($sformatf("err_t%0d", e.target), err, e.err);
                check($sformatf("steps_t%0d", e.target), steps, e.steps);
                check($sformatf("latency_t%0d", e.target), cyc, e.steps);
                check($sformatf("guesses_left_t%0d", e.target), gexp_q.size(), 0);
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        flags_off = 1'b0;
        start = 1'b0;
        if (!seen) begin
            check($sformatf("done_timeout_t%0d", v.target), 0, 1);
            void'(exp_q.pop_front());
        end else begin
            @(negedge clk);
            check($sformatf("done_pulse_t%0d", v.target), done, 0);
            check($sformatf("held_t%0d", v.target), result, v.res);
        end
    endtask

    initial begin
        int   wait_cyc;
        vec_t v;
        tbl[0] = '{4'd5,  4'd5,  1'b1, 1'b0, 3'd4, 16'h5648, -1, 1'b0};
        tbl[1] = '{4'd8,  4'd8,  1'b1, 1'b0, 3'd1, 16'h0008, -1, 1'b0};
        tbl[2] = '{4'd0,  4'd0,  1'b0, 1'b0, 3'd4, 16'h1248, -1, 1'b0};
        tbl[3] = '{4'd15, 4'd15, 1'b1, 1'b0, 3'd4, 16'hFEC8, -1, 1'b0};
        tbl[4] = '{4'd3,  4'd3,  1'b1, 1'b0, 3'd4, 16'h3248, -1, 1'b1};
        tbl[5] = '{4'd5,  4'd0,  1'b0, 1'b1, 3'd2, 16'h0048,  1, 1'b0};

        #2;
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {found, err}, 0);
        check("rst_steps", steps, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run(tbl[i]);
        for (int t = 0; t < 16; t++) begin
            v = model(4'(t));
            v.poke = (t % 3 == 0);
            run(v);
        end

        // start seen in the done cycle is ignored; still high next cycle it is accepted.
        target = 4'd6;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!done && wait_cyc < 12) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("restart_done_seen", done, 1);
        start = 1'b1;
        @(negedge clk);
        check("restart_ignored_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("restart_accepted_busy", busy, 1);
        check("restart_guess", guess, 8);
        wait_cyc = 0;
        while (!done && wait_cyc < 12) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("restart_result", result, 6);

        // Reset mid-search clears everything at once and no done follows.
        @(negedge clk);
        @(negedge clk);
        target = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_guess", guess, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_steps", steps, 0);
        check("arst_flags", {done, found, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_done_c%0d", i), done, 0);
            check($sformatf("post_rst_busy_c%0d", i), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
